// File: rtl/mreq_exec_if.sv
// mreq_exec_if: groups the request handshake, the write-data rx stream, the
// read-data tx stream and the word bus of mreq_exec into one bundle.
// Signal names keep their i_/o_ prefixes as seen from mreq_exec, so the
// slave modport reads naturally on the executor side.
interface mreq_exec_if;

  // Request handshake from cmd_rx
  logic        i_mreq_valid;
  logic        o_mreq_ready;
  logic        i_mreq_wr;
  logic [1:0]  i_mreq_wsize;
  logic        i_mreq_aincr;
  logic [7:0]  i_mreq_wcount;
  logic [31:0] i_mreq_addr;

  // Write-data byte stream (shared rx stream)
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;

  // Read-data byte stream
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;

  // Word bus
  logic        o_bus_req;
  logic        o_bus_we;
  logic [1:0]  o_bus_size;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;

  // Executor side
  modport slave (
    input  i_mreq_valid, i_mreq_wr, i_mreq_wsize, i_mreq_aincr,
    input  i_mreq_wcount, i_mreq_addr,
    output o_mreq_ready,
    input  i_rx_valid, i_rx_data,
    output o_rx_ready,
    output o_tx_valid, o_tx_data,
    input  i_tx_ready,
    output o_bus_req, o_bus_we, o_bus_size, o_bus_addr, o_bus_wdata,
    input  i_bus_ack, i_bus_rdata
  );

  // Environment side (request source, stream endpoints, bus target)
  modport master (
    output i_mreq_valid, i_mreq_wr, i_mreq_wsize, i_mreq_aincr,
    output i_mreq_wcount, i_mreq_addr,
    input  o_mreq_ready,
    output i_rx_valid, i_rx_data,
    input  o_rx_ready,
    input  o_tx_valid, o_tx_data,
    output i_tx_ready,
    input  o_bus_req, o_bus_we, o_bus_size, o_bus_addr, o_bus_wdata,
    output i_bus_ack, i_bus_rdata
  );

endinterface : mreq_exec_if

// File: rtl/mreq_exec.sv
// mreq_exec: executes one decoded memory request at a time as a run of
// word accesses on a simple req/ack bus. Write words are assembled from the
// rx byte stream; read words are serialized little-endian onto tx.
// Optional feature: define MREQ_EXEC_TIMEOUT_EN to build a bus-ack timeout
// of TIMEOUT_CYCLES cycles that force-completes a stuck access and pulses
// o_err_timeout. Without the macro the block waits for ack indefinitely.
module mreq_exec #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  mreq_exec_if.slave  mif,
  output logic        o_busy,
  output logic        o_err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_COLLECT,
    ST_WR_BUS,
    ST_RD_BUS,
    ST_RD_SEND
  } state_e;

  // Reject a timeout that the 16-bit counter cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mreq_exec: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;        // effective size code, never 3
  logic        aincr_q, aincr_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;          // words still to run
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        bus_active;
  logic        timeout_fire;
  logic        access_done;
  logic [1:0]  last_idx;
  logic [31:0] step;
  logic [31:0] addr_next;

  // Word geometry derived from the latched size code.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    last_idx = 2'd3;
    step     = 32'd4;
    unique case (size_q)
      2'd0:    begin last_idx = 2'd0; step = 32'd1; end
      2'd1:    begin last_idx = 2'd1; step = 32'd2; end
      default: begin last_idx = 2'd3; step = 32'd4; end
    endcase
  end

  assign bus_active  = (state_q == ST_WR_BUS) || (state_q == ST_RD_BUS);
  // Ack is only meaningful while req is up; a stray ack elsewhere is ignored.
  assign access_done = bus_active && (mif.i_bus_ack || timeout_fire);
  // 32-bit add wraps naturally past 0xFFFFFFFF.
  assign addr_next   = aincr_q ? (addr_q + step) : addr_q;

`ifdef MREQ_EXEC_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q, to_cnt_d;
  logic        err_timeout_q, err_timeout_d;

  // The access is forced complete on the edge that would make the count of
  // unacknowledged req cycles reach TIMEOUT_CYCLES.
  assign timeout_fire = bus_active && !mif.i_bus_ack && (to_cnt_q == TO_LAST);

  // Count unacknowledged req cycles; outside an access the count rests at 0,
  // so every entry to a bus state starts from a cleared counter.
  always_comb begin
    to_cnt_d      = '0;
    err_timeout_d = timeout_fire;
    if (bus_active && !access_done) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  // Timeout counter and one-cycle error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign o_err_timeout = err_timeout_q;
`else
  assign timeout_fire  = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  // Next-state and datapath updates for the request sequencer.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    size_d     = size_q;
    aincr_d    = aincr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mif.i_mreq_valid && ready_q) begin
          wr_d       = mif.i_mreq_wr;
          size_d     = (mif.i_mreq_wsize == 2'd3) ? 2'd2 : mif.i_mreq_wsize;
          aincr_d    = mif.i_mreq_aincr;
          addr_d     = mif.i_mreq_addr;
          cnt_d      = mif.i_mreq_wcount;
          byte_idx_d = 2'd0;
          // A zero-word request is consumed without leaving IDLE.
          if (mif.i_mreq_wcount != 8'd0) begin
            state_d = mif.i_mreq_wr ? ST_WR_COLLECT : ST_RD_BUS;
          end
        end
      end

      ST_WR_COLLECT: begin
        if (mif.i_rx_valid) begin
          // Lane 0 restarts the word so unused upper bytes read as zero.
          if (byte_idx_q == 2'd0) begin
            wdata_d = {24'd0, mif.i_rx_data};
          end else begin
            wdata_d[{byte_idx_q, 3'b000} +: 8] = mif.i_rx_data;
          end
          if (byte_idx_q == last_idx) begin
            byte_idx_d = 2'd0;
            state_d    = ST_WR_BUS;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      ST_WR_BUS: begin
        // A timed-out write is simply dropped; sequencing is unchanged.
        if (access_done) begin
          addr_d  = addr_next;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? ST_IDLE : ST_WR_COLLECT;
        end
      end

      ST_RD_BUS: begin
        if (access_done) begin
          rdata_d = mif.i_bus_ack ? mif.i_bus_rdata : 32'd0;
          addr_d  = addr_next;
          cnt_d   = cnt_q - 8'd1;
          state_d = ST_RD_SEND;
        end
      end

      ST_RD_SEND: begin
        if (mif.i_tx_ready) begin
          if (byte_idx_q == last_idx) begin
            byte_idx_d = 2'd0;
            state_d    = (cnt_q == 8'd0) ? ST_IDLE : ST_RD_BUS;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Request ready is registered: it follows the state we are about to be in.
    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: every register, data included, is cleared by the asynchronous
    // reset so an aborted request leaves nothing behind and all outputs read
    // 0 while reset is held.
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      aincr_q    <= 1'b0;
      addr_q     <= 32'd0;
      cnt_q      <= 8'd0;
      byte_idx_q <= 2'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge regardless of statement order.
      state_q    <= state_d;
      ready_q    <= ready_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      aincr_q    <= aincr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Outputs decoded from the registered state.
  assign mif.o_mreq_ready = ready_q;
  assign mif.o_rx_ready   = (state_q == ST_WR_COLLECT);
  assign mif.o_tx_valid   = (state_q == ST_RD_SEND);
  assign mif.o_tx_data    = (state_q == ST_RD_SEND) ?
                            rdata_q[{byte_idx_q, 3'b000} +: 8] : 8'd0;
  assign mif.o_bus_req    = bus_active;
  assign mif.o_bus_we     = (state_q == ST_WR_BUS);
  assign mif.o_bus_size   = size_q;
  assign mif.o_bus_addr   = addr_q;
  assign mif.o_bus_wdata  = wdata_q;
  assign o_busy           = (state_q != ST_IDLE);

endmodule : mreq_exec
